// File: rtl/vram_pkg.sv
// Shared types and widths for the video RAM arbiter: grant encoding and the
// read-return tag that travels alongside each RAM read.
package vram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    G_NONE,
    G_VGA,
    G_CPU_RD,
    G_CPU_WR
  } grant_t;

  typedef enum logic {
    OWN_VGA,
    OWN_CPU
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   err;
  } rd_tag_t;

  function automatic logic is_cpu(input grant_t g);
    return (g == G_CPU_RD) || (g == G_CPU_WR);
  endfunction

endpackage

// File: rtl/vram_if.sv
// Bus bundle between the arbiter (slave side) and its two requesters plus the
// single-port RAM macro (master side, driven by whoever hosts the arbiter).
interface vram_if;
  import vram_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_ack, vga_rdata, vga_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
           cpu_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_ack, vga_rdata, vga_rvalid, cpu_ack, cpu_rdata, cpu_rvalid,
           cpu_err, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// Two-stage read tag shift register that lines up with the RAM's one-cycle read
// latency and steers the returned word to the VGA or CPU read port.
module vram_rd_pipe
  import vram_pkg::*;
(
  input  logic              clock,
  input  logic              clear_n,
  input  rd_tag_t           i_tag,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_vga_rdata,
  output logic              o_vga_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid
);

  rd_tag_t           r_stage1;
  rd_tag_t           r_stage2;
  logic [DATA_W-1:0] r_vga_rdata;
  logic              r_vga_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] w_ret_data;
  logic              w_ret_vga;
  logic              w_ret_cpu;

  always_comb begin
    w_ret_data = r_stage2.err ? '0 : i_mem_rdata;
    w_ret_vga  = r_stage2.valid && (r_stage2.owner == OWN_VGA);
    w_ret_cpu  = r_stage2.valid && (r_stage2.owner == OWN_CPU);
  end

  // Clearing the tags on reset is what drops in-flight reads: no rvalid can
  // surface after release for a read granted before it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_stage1     <= '0;
      r_stage2     <= '0;
      r_vga_rdata  <= '0;
      r_vga_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_stage1     <= i_tag;
      r_stage2     <= r_stage1;
      r_vga_rvalid <= w_ret_vga;
      r_cpu_rvalid <= w_ret_cpu;
      if (w_ret_vga) r_vga_rdata <= w_ret_data;
      if (w_ret_cpu) r_cpu_rdata <= w_ret_data;
    end
  end

  assign o_vga_rdata  = r_vga_rdata;
  assign o_vga_rvalid = r_vga_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_rvalid = r_cpu_rvalid;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: VGA scanout has priority, a saturating wait
// counter lets a starved CPU request override it. One RAM access per clock.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int MEM_WORDS    = 65536,
  parameter int CPU_MAX_WAIT = 4
) (
  input logic  clock,
  input logic  clear_n,
  vram_if.slave bus
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  grant_t            w_grant;
  logic              w_cpu_gnt;
  logic              w_cpu_oow;
  rd_tag_t           w_tag;
  logic [3:0]        r_wait_cnt;
  logic              r_vga_ack;
  logic              r_cpu_ack;
  logic              r_cpu_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // NOTE: every variable in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_cpu_oow = 32'(bus.cpu_addr) >= 32'(MEM_WORDS);
    w_grant   = G_NONE;
    if (bus.cpu_req && ((r_wait_cnt == MAX_WAIT) || !bus.vga_req))
      w_grant = bus.cpu_we ? G_CPU_WR : G_CPU_RD;
    else if (bus.vga_req)
      w_grant = G_VGA;
    w_cpu_gnt = is_cpu(w_grant);

    w_tag.valid = (w_grant == G_VGA) || (w_grant == G_CPU_RD);
    w_tag.owner = (w_grant == G_VGA) ? OWN_VGA : OWN_CPU;
    w_tag.err   = (w_grant == G_CPU_RD) && w_cpu_oow;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_wait_cnt <= '0;
    end else if (!bus.cpu_req || w_cpu_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // An out-of-window write is acked with err but never reaches the RAM.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_vga_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_vga_ack <= (w_grant == G_VGA);
      r_cpu_ack <= w_cpu_gnt;
      r_cpu_err <= w_cpu_gnt && w_cpu_oow;
      r_mem_we  <= (w_grant == G_CPU_WR) && !w_cpu_oow;
      if (w_grant != G_NONE) begin
        r_mem_addr  <= (w_grant == G_VGA) ? bus.vga_addr : bus.cpu_addr;
        r_mem_wdata <= bus.cpu_wdata;
      end
    end
  end

  assign bus.vga_ack   = r_vga_ack;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

  vram_rd_pipe u_rd_pipe (
    .clock       (clock),
    .clear_n     (clear_n),
    .i_tag       (w_tag),
    .i_mem_rdata (bus.mem_rdata),
    .o_vga_rdata (bus.vga_rdata),
    .o_vga_rvalid(bus.vga_rvalid),
    .o_cpu_rdata (bus.cpu_rdata),
    .o_cpu_rvalid(bus.cpu_rvalid)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM and a
// handshake monitor; expected values are hand-computed per cycle.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  logic [15:0] ram [0:65535];
  logic vga_prev = 1'b0;
  logic cpu_prev = 1'b0;

  // Expected {vga_ack, cpu_ack, cpu_err, vga_rvalid, cpu_rvalid} per cycle
  // of the contention scenario, starting with the first cycle cpu_req is high.
  localparam logic [4:0] CONT_EXP [9] = '{
    5'b10000, 5'b10010, 5'b10010, 5'b10010, 5'b01010,
    5'b10010, 5'b00001, 5'b00010, 5'b00000
  };

  vram_if bus();

  vram_arbiter #(.MEM_WORDS(32768), .CPU_MAX_WAIT(4)) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clock) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
  end

  // Requesters must hold req until acked; rvalids must never coincide.
  always @(negedge clock) begin
    if (!clear_n) begin
      vga_prev = 1'b0;
      cpu_prev = 1'b0;
    end else begin
      if (vga_prev && !bus.vga_ack && !bus.vga_req) begin
        errors++;
        $display("FAIL proto_vga: vga_req dropped before vga_ack");
      end
      if (cpu_prev && !bus.cpu_ack && !bus.cpu_req) begin
        errors++;
        $display("FAIL proto_cpu: cpu_req dropped before cpu_ack");
      end
      if (bus.vga_rvalid && bus.cpu_rvalid) begin
        errors++;
        $display("FAIL rvalid_overlap: both rvalids high at %0t", $time);
      end
      vga_prev = bus.vga_req;
      cpu_prev = bus.cpu_req;
    end
  end

  function automatic logic [4:0] flags();
    return {bus.vga_ack, bus.cpu_ack, bus.cpu_err, bus.vga_rvalid, bus.cpu_rvalid};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.vga_req   = 1'($urandom);
      bus.vga_addr  = 16'($urandom);
      bus.cpu_req   = 1'($urandom);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = 16'($urandom);
      bus.cpu_wdata = 16'($urandom);
      tick();
      checks++;
      if ({flags(), bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.vga_rdata, bus.cpu_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: flags=%b mem_we=%b mem_addr=%h, required all zero",
                 i, flags(), bus.mem_we, bus.mem_addr);
      end
    end
    idle();
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({flags(), bus.mem_we} !== 6'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: flags=%b mem_we=%b, required 0", i, flags(), bus.mem_we);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hA5C3;
    tick();
    checks++;
    if ({flags(), bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {5'b01000, 1'b1, 16'h0010, 16'hA5C3}) begin
      errors++;
      $display("FAIL wr_issue: flags=%b we=%b addr=%h wdata=%h, required 01000 1 0010 a5c3",
               flags(), bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.cpu_we = 1'b0;
    tick();
    checks++;
    if ({flags(), bus.mem_we} !== {5'b01000, 1'b0}) begin
      errors++;
      $display("FAIL rd_issue: flags=%b we=%b, required 01000 0", flags(), bus.mem_we);
    end
    bus.cpu_req = 1'b0;
    tick();
    checks++;
    if (flags() !== 5'b00000) begin
      errors++;
      $display("FAIL rd_gap: flags=%b, required 00000", flags());
    end
    tick();
    checks++;
    if ({flags(), bus.cpu_rdata} !== {5'b00001, 16'hA5C3}) begin
      errors++;
      $display("FAIL rd_return: flags=%b rdata=%h, required 00001 a5c3", flags(), bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0200;
    tick();
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL cont_start: flags=%b, required 10000", flags());
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (flags() !== CONT_EXP[k-1]) begin
        errors++;
        $display("FAIL cont_cycle[%0d]: flags=%b, required %b", k, flags(), CONT_EXP[k-1]);
      end
      if (k == 5) begin
        checks++;
        if (bus.mem_addr !== 16'h0020) begin
          errors++;
          $display("FAIL cont_override_addr: mem_addr=%h, required 0020", bus.mem_addr);
        end
        bus.cpu_req = 1'b0;
      end
      if (k == 6) bus.vga_req = 1'b0;
      if (k == 7) begin
        checks++;
        if (bus.cpu_rdata !== 16'h0C0C) begin
          errors++;
          $display("FAIL cont_cpu_data: cpu_rdata=%h, required 0c0c", bus.cpu_rdata);
        end
      end
      if (k == 8) begin
        checks++;
        if (bus.vga_rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL cont_vga_data: vga_rdata=%h, required beef", bus.vga_rdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 16'h1234;
    tick();
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL simul_vga_first: flags=%b, required 10000", flags());
    end
    bus.vga_req = 1'b0;
    tick();
    checks++;
    if ({flags(), bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {5'b01000, 1'b1, 16'h0100, 16'h1234}) begin
      errors++;
      $display("FAIL simul_cpu_write: flags=%b we=%b addr=%h wdata=%h, required 01000 1 0100 1234",
               flags(), bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.cpu_we = 1'b0;
    tick();
    checks++;
    if ({flags(), bus.vga_rdata} !== {5'b01010, 16'h0000}) begin
      errors++;
      $display("FAIL simul_vga_old: flags=%b vga_rdata=%h, required 01010 0000", flags(), bus.vga_rdata);
    end
    bus.cpu_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({flags(), bus.cpu_rdata} !== {5'b00001, 16'h1234}) begin
      errors++;
      $display("FAIL simul_cpu_new: flags=%b cpu_rdata=%h, required 00001 1234", flags(), bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_out_of_window();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h9000; bus.cpu_wdata = 16'hDEAD;
    tick();
    checks++;
    if ({flags(), bus.mem_we, bus.mem_addr} !== {5'b01100, 1'b0, 16'h9000}) begin
      errors++;
      $display("FAIL oow_write: flags=%b we=%b addr=%h, required 01100 0 9000",
               flags(), bus.mem_we, bus.mem_addr);
    end
    bus.cpu_we = 1'b0;
    tick();
    checks++;
    if (flags() !== 5'b01100) begin
      errors++;
      $display("FAIL oow_read_ack: flags=%b, required 01100", flags());
    end
    bus.cpu_req = 1'b0;
    tick();
    checks++;
    if (ram[16'h9000] !== 16'h7777) begin
      errors++;
      $display("FAIL oow_ram_kept: ram[9000]=%h, required 7777", ram[16'h9000]);
    end
    tick();
    checks++;
    if ({flags(), bus.cpu_rdata} !== {5'b00001, 16'h0000}) begin
      errors++;
      $display("FAIL oow_read_zero: flags=%b cpu_rdata=%h, required 00001 0000", flags(), bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0200;
    tick();
    checks++;
    if (flags() !== 5'b10000) begin
      errors++;
      $display("FAIL inflight_ack: flags=%b, required 10000", flags());
    end
    bus.vga_req = 1'b0;
    tick();
    clear_n = 1'b0;
    #1;
    checks++;
    if ({flags(), bus.mem_we, bus.mem_addr, bus.vga_rdata} !== '0) begin
      errors++;
      $display("FAIL inflight_async_clear: flags=%b mem_addr=%h vga_rdata=%h, required all zero",
               flags(), bus.mem_addr, bus.vga_rdata);
    end
    tick();
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (flags() !== 5'b00000) begin
        errors++;
        $display("FAIL inflight_dropped[%0d]: flags=%b, required 00000", i, flags());
      end
    end
    bus.vga_req = 1'b1;
    tick();
    bus.vga_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({flags(), bus.vga_rdata} !== {5'b00010, 16'hBEEF}) begin
      errors++;
      $display("FAIL inflight_recover: flags=%b vga_rdata=%h, required 00010 beef", flags(), bus.vga_rdata);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
    ram[16'h0200] = 16'hBEEF;
    ram[16'h0020] = 16'h0C0C;
    ram[16'h9000] = 16'h7777;
    idle();
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_simultaneous();
    test_out_of_window();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
